if_fetch_unit: RTL and testbench

//  IF stage plus IF/ID pipeline register. Holds the PC and drives the instruction ROM.

---
 rtl/if_fetch_unit_if.sv | 42 ++++
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
//  Bundles every non-clock, non-reset signal of the fetch unit.
//  master : the environment side (ctrl, ID stage, instruction ROM).
//  slave  : the fetch unit itself.
//  Signals:
//   stall_if, stall_id, flush, new_pc        ctrl -> fetch
//   branch_flag_i, branch_target_address_i   ID   -> fetch
//   inst_rom_data_i                          ROM  -> fetch
//   inst_rom_ce_o, inst_rom_addr_o           fetch -> ROM
//   id_pc_o, id_inst_o                       fetch -> ID
//   fetch_cnt_o, bubble_cnt_o                performance counters
// ----------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_rom_data_i;
    logic        inst_rom_ce_o;
    logic [31:0] inst_rom_addr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;

    modport master (
        output stall_if, stall_id, flush, new_pc,
        output branch_flag_i, branch_target_address_i, inst_rom_data_i,
        input  inst_rom_ce_o, inst_rom_addr_o, id_pc_o, id_inst_o,
        input  fetch_cnt_o, bubble_cnt_o
    );

    modport slave (
        input  stall_if, stall_id, flush, new_pc,
        input  branch_flag_i, branch_target_address_i, inst_rom_data_i,
        output inst_rom_ce_o, inst_rom_addr_o, id_pc_o, id_inst_o,
        output fetch_cnt_o, bubble_cnt_o
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//  MIPS IF stage plus IF/ID pipeline register. Holds the PC, drives the
//  instruction ROM and presents pc/inst to ID. Branch requests from ID honour
//  the delay slot; a branch arriving while IF is stalled is parked and taken
//  once the stall releases. An exception flush redirects to new_pc and
//  overrides everything else.
//  Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-low
//   bus  if_fetch_unit_if.slave (controls, branch, ROM, IF/ID outputs, counters)
//  Parameter:
//   RESET_PC  PC loaded on reset, first fetch address
//  Build option:
//   IF_FETCH_PERF_CNT_EN  when defined, fetch_cnt_o / bubble_cnt_o count
//                         IF/ID loads of real instructions and of bubbles;
//                         otherwise both ports are tied to zero.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_unit_if.slave bus
);

    // ce doubles as the FSM state: BOOT idles the ROM for one cycle after reset
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        ce;

    assign ce = (state_q == RUN);

    assign bus.inst_rom_ce_o   = ce;
    assign bus.inst_rom_addr_o = pc_q;
    assign bus.id_pc_o         = id_pc_q;
    assign bus.id_inst_o       = id_inst_q;

    // ---- IF stage: state, PC and parked-branch next values ----
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;

        if (state_q == BOOT) begin
            state_d = RUN;
        end else begin
            if (bus.flush) begin
                pc_d       = bus.new_pc;
                pend_vld_d = 1'b0;
            end else if (bus.stall_if && bus.branch_flag_i) begin
                // newest target wins even if one is already parked
                pend_vld_d = 1'b1;
                pend_tgt_d = bus.branch_target_address_i;
            end else if (bus.stall_if) begin
                pc_d = pc_q;
            end else if (bus.branch_flag_i) begin
                pc_d       = bus.branch_target_address_i;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                pc_d       = pend_tgt_q;
                pend_vld_d = 1'b0;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // ---- IF/ID register next values ----
    always_comb begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;

        if (bus.flush) begin
            id_pc_d   = 32'h0;
            id_inst_d = 32'h0;
        end else if (bus.stall_id) begin
            id_pc_d   = id_pc_q;
            id_inst_d = id_inst_q;
        end else if (bus.stall_if || !ce) begin
            // ID keeps moving while IF is held or idle: feed it a nop
            id_pc_d   = 32'h0;
            id_inst_d = 32'h0;
        end else begin
            id_pc_d   = pc_q;
            id_inst_d = bus.inst_rom_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0;
            id_pc_q    <= 32'h0;
            id_inst_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic        load_fetch;
    logic        load_bubble;

    // a hold (stall_id without flush) loads nothing and counts nothing
    always_comb begin
        load_fetch  = 1'b0;
        load_bubble = 1'b0;
        if (bus.flush) begin
            load_bubble = 1'b1;
        end else if (!bus.stall_id) begin
            if (bus.stall_if || !ce) begin
                load_bubble = 1'b1;
            end else begin
                load_fetch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (load_fetch) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (load_bubble) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign bus.fetch_cnt_o  = fetch_cnt_q;
    assign bus.bubble_cnt_o = bubble_cnt_q;
`else
    assign bus.fetch_cnt_o  = 32'h0;
    assign bus.bubble_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//  Directed bench for if_fetch_unit. The instruction ROM is a combinational
//  function of the address so every fetched word is distinct and non-zero.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic clk;
    logic rst;
    int   vec;
    int   miss;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef IF_FETCH_PERF_CNT_EN
    localparam logic [31:0] EXP_FETCH  = 32'd5;
    localparam logic [31:0] EXP_BUBBLE = 32'd2;
`else
    localparam logic [31:0] EXP_FETCH  = 32'd0;
    localparam logic [31:0] EXP_BUBBLE = 32'd0;
`endif

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[15:0]};
    endfunction

    assign bus.inst_rom_data_i = rom(bus.inst_rom_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall_if                = 1'b0;
        bus.stall_id                = 1'b0;
        bus.flush                   = 1'b0;
        bus.new_pc                  = 32'h0;
        bus.branch_flag_i           = 1'b0;
        bus.branch_target_address_i = 32'h0;
    endtask

    // observed/expected packed as {ce, addr, id_pc, id_inst}
    task automatic test_reset();
        logic [96:0] exp;
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        exp = {1'b0, 32'h0, 32'h0, 32'h0};
        vec++;
        if ({bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL reset_state got %h want %h",
                     {bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        rst = 1'b1;
        step();
        exp = {1'b1, 32'h0, 32'h0, 32'h0};
        vec++;
        if ({bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL boot_bubble got %h want %h",
                     {bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        step();
        exp = {1'b1, 32'h4, 32'h0, rom(32'h0)};
        vec++;
        if ({bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL seq_addr4 got %h want %h",
                     {bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        step();
        exp = {1'b1, 32'h8, 32'h4, rom(32'h4)};
        vec++;
        if ({bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL seq_addr8 got %h want %h",
                     {bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        for (int i = 0; i < 7; i++) step();
        exp = {1'b1, 32'h24, 32'h20, rom(32'h20)};
        vec++;
        if ({bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL seq_addr24 got %h want %h",
                     {bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
    endtask

    task automatic test_branch();
        logic [95:0] exp;
        bus.branch_flag_i           = 1'b1;
        bus.branch_target_address_i = 32'h100;
        step();
        idle_inputs();
        exp = {32'h100, 32'h24, rom(32'h24)};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL branch_delay_slot got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        step();
        exp = {32'h104, 32'h100, rom(32'h100)};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL branch_target got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
    endtask

    task automatic test_stalled_branch();
        logic [95:0] exp;
        bus.stall_if                = 1'b1;
        bus.branch_flag_i           = 1'b1;
        bus.branch_target_address_i = 32'h200;
        step();
        exp = {32'h104, 32'h0, 32'h0};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL stall_br_cycle1 got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        step();
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL stall_br_cycle2 got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        idle_inputs();
        step();
        exp = {32'h200, 32'h104, rom(32'h104)};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL stall_br_release got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        step();
        exp = {32'h204, 32'h200, rom(32'h200)};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL stall_br_target got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
    endtask

    task automatic test_flush();
        logic [95:0] exp;
        // park a branch first
        bus.stall_if                = 1'b1;
        bus.branch_flag_i           = 1'b1;
        bus.branch_target_address_i = 32'h280;
        step();
        bus.stall_if                = 1'b0;
        bus.flush                   = 1'b1;
        bus.new_pc                  = 32'h80;
        bus.branch_target_address_i = 32'h300;
        step();
        idle_inputs();
        exp = {32'h80, 32'h0, 32'h0};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL flush_redirect got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        step();
        exp = {32'h84, 32'h80, rom(32'h80)};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL flush_drops_pend got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
    endtask

    task automatic test_wrap();
        logic [95:0] exp;
        bus.flush  = 1'b1;
        bus.new_pc = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        exp = {32'h0, 32'hFFFF_FFFC, rom(32'hFFFF_FFFC)};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL pc_wrap got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        step();
        exp = {32'h4, 32'h0, rom(32'h0)};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL after_wrap got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
    endtask

    task automatic test_stall_id_hold();
        logic [95:0] exp;
        bus.stall_if = 1'b1;
        bus.stall_id = 1'b1;
        step();
        step();
        exp = {32'h4, 32'h0, rom(32'h0)};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL stall_id_hold got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        idle_inputs();
        step();
        exp = {32'h8, 32'h4, rom(32'h4)};
        vec++;
        if ({bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL stall_id_release got %h want %h",
                     {bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
    endtask

    task automatic test_reset_in_stall();
        logic [96:0] exp;
        logic [63:0] cexp;
        rst = 1'b0;
        idle_inputs();
        step();
        rst = 1'b1;
        step();                              // boot edge: one bubble
        for (int i = 0; i < 5; i++) step();  // five fetches
        bus.stall_if                = 1'b1;  // one more bubble, branch parked
        bus.branch_flag_i           = 1'b1;
        bus.branch_target_address_i = 32'h500;
        step();
        bus.branch_flag_i = 1'b0;
        exp = {1'b1, 32'h14, 32'h0, 32'h0};
        vec++;
        if ({bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL pre_reset_state got %h want %h",
                     {bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        cexp = {EXP_FETCH, EXP_BUBBLE};
        vec++;
        if ({bus.fetch_cnt_o, bus.bubble_cnt_o} !== cexp) begin
            miss++;
            $display("FAIL perf_counts got %h want %h", {bus.fetch_cnt_o, bus.bubble_cnt_o}, cexp);
        end
        rst = 1'b0;
        step();
        exp = {1'b0, 32'h0, 32'h0, 32'h0};
        vec++;
        if ({bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL reset_in_stall got %h want %h",
                     {bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
        cexp = 64'h0;
        vec++;
        if ({bus.fetch_cnt_o, bus.bubble_cnt_o} !== cexp) begin
            miss++;
            $display("FAIL perf_clear got %h want %h", {bus.fetch_cnt_o, bus.bubble_cnt_o}, cexp);
        end
        rst = 1'b1;
        bus.stall_if = 1'b0;
        step();
        step();
        exp = {1'b1, 32'h4, 32'h0, rom(32'h0)};
        vec++;
        if ({bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o} !== exp) begin
            miss++;
            $display("FAIL restart_no_pend got %h want %h",
                     {bus.inst_rom_ce_o, bus.inst_rom_addr_o, bus.id_pc_o, bus.id_inst_o}, exp);
        end
    endtask

    initial begin
        vec  = 0;
        miss = 0;
        test_reset();
        test_branch();
        test_stalled_branch();
        test_flush();
        test_wrap();
        test_stall_id_hold();
        test_reset_in_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
